aes_csr_bus_bridge: RTL



---
 rtl/aes_csr_bus_bridge_pkg.sv | 33 +++
 rtl/aes_csr_bus_bridge_if.sv | 58 +++++
 rtl/aes_csr_req_check.sv | 45 ++++
 rtl/aes_csr_bus_bridge.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/aes_csr_bus_bridge_pkg.sv
// Shared types and constants for the AES CSR bus bridge.
//   - default bus widths and the byte-mask width that follows from them
//   - ALL_ONES_MASK: the only mask a Put may carry (no partial writes)
//   - A-channel and D-channel opcode enums
//   - FSM state encoding, used by the top module and its debug output
package aes_csr_bus_bridge_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_SRC_W  = 8;
  localparam int BUS_MASK_W = BUS_DATA_W / 8;

  // One mask bit per data byte, all set.
  localparam logic [BUS_MASK_W-1:0] ALL_ONES_MASK = {BUS_MASK_W{1'b1}};

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } d_opcode_e;

  // FSM state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

endpackage

// File: rtl/aes_csr_bus_bridge_if.sv
// Bus bundle between a TL-UL-style requester, the bridge and the CSR side.
// Signal names carry the direction as seen from the bridge.
//
// Handshake rules (both channels): a beat transfers on a rising clock edge
// where valid and ready are both high. A source that raised valid keeps it
// high, with its payload stable, until that edge. A-channel and D-channel
// never have a beat in flight at the same time (one outstanding request).
//
// CSR side: acc_en_o is a single-cycle strobe. wr_en_o/addr_o/wdata_o are
// meaningful only while acc_en_o is high. rdata_i is sampled in that cycle.
//
// Modports:
//   slave  - the bridge
//   master - the requester plus CSR target (e.g. a testbench)
interface aes_csr_bus_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SRC_WIDTH  = 8
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  // A channel
  logic                  a_valid_i;
  logic                  a_ready_o;
  logic [2:0]            a_opcode_i;
  logic [ADDR_WIDTH-1:0] a_address_i;
  logic [DATA_WIDTH-1:0] a_data_i;
  logic [MASK_WIDTH-1:0] a_mask_i;
  logic [SRC_WIDTH-1:0]  a_source_i;
  // D channel
  logic                  d_valid_o;
  logic                  d_ready_i;
  logic [2:0]            d_opcode_o;
  logic [DATA_WIDTH-1:0] d_data_o;
  logic [SRC_WIDTH-1:0]  d_source_o;
  logic                  d_error_o;
  // CSR strobe interface
  logic                  acc_en_o;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic [DATA_WIDTH-1:0] rdata_i;

  modport slave (
    input  a_valid_i, a_opcode_i, a_address_i, a_data_i, a_mask_i, a_source_i,
    input  d_ready_i, rdata_i,
    output a_ready_o, d_valid_o, d_opcode_o, d_data_o, d_source_o, d_error_o,
    output acc_en_o, wr_en_o, addr_o, wdata_o
  );

  modport master (
    output a_valid_i, a_opcode_i, a_address_i, a_data_i, a_mask_i, a_source_i,
    output d_ready_i, rdata_i,
    input  a_ready_o, d_valid_o, d_opcode_o, d_data_o, d_source_o, d_error_o,
    input  acc_en_o, wr_en_o, addr_o, wdata_o
  );

endinterface

// File: rtl/aes_csr_req_check.sv
// Combinational legality decode for one A-channel request.
// Ports:
//   a_opcode_i    - request opcode
//   a_addr_lsb_i  - two low byte-address bits (word alignment)
//   a_mask_i      - byte mask
//   err_o         - request must be rejected
//   is_get_o      - opcode is Get
module aes_csr_req_check
  import aes_csr_bus_bridge_pkg::*;
#(
  parameter int MASK_WIDTH = BUS_MASK_W
) (
  input  logic [2:0]            a_opcode_i,
  input  logic [1:0]            a_addr_lsb_i,
  input  logic [MASK_WIDTH-1:0] a_mask_i,
  output logic                  err_o,
  output logic                  is_get_o
);

  logic op_legal;
  logic is_put;

  always_comb begin
    op_legal = 1'b0;
    is_put   = 1'b0;
    is_get_o = 1'b0;
    case (a_opcode_i)
      PutFullData, PutPartialData: begin
        op_legal = 1'b1;
        is_put   = 1'b1;
      end
      Get: begin
        op_legal = 1'b1;
        is_get_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Writes must cover the whole word; a Get's mask is don't-care.
  assign err_o = !op_legal
              || (a_addr_lsb_i != 2'b00)
              || (is_put && !(&a_mask_i));

endmodule

// File: rtl/aes_csr_bus_bridge.sv
// Bridge from a single-outstanding TL-UL-style bus to the CSR strobe.
// Each request walks IDLE -> ACCESS -> RESP. ACCESS is the single cycle in
// which the CSR strobe fires (legal requests only) and read data is captured.
// RESP holds the D-channel beat until it is accepted.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   bus            - A/D channels and CSR strobe interface (slave side)
//   dbg_state_o    - current FSM state
module aes_csr_bus_bridge
  import aes_csr_bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_W,
  parameter int DATA_WIDTH = BUS_DATA_W,
  parameter int SRC_WIDTH  = BUS_SRC_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  aes_csr_bus_bridge_if.slave       bus,
  output state_t                    dbg_state_o
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  state_t                state_q, state_d;
  logic                  a_ready_q, a_ready_d;
  logic                  d_valid_q, d_valid_d;
  logic                  err_q, err_d;
  logic                  is_get_q, is_get_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  d_opcode_e             d_opcode_q, d_opcode_d;
  logic [DATA_WIDTH-1:0] d_data_q, d_data_d;
  logic [SRC_WIDTH-1:0]  d_source_q, d_source_d;
  logic                  acc_en;

  logic req_err;
  logic req_is_get;

  aes_csr_req_check #(
    .MASK_WIDTH (MASK_WIDTH)
  ) u_req_check (
    .a_opcode_i   (bus.a_opcode_i),
    .a_addr_lsb_i (bus.a_address_i[1:0]),
    .a_mask_i     (bus.a_mask_i),
    .err_o        (req_err),
    .is_get_o     (req_is_get)
  );

  always_comb begin
    state_d    = state_q;
    a_ready_d  = a_ready_q;
    d_valid_d  = d_valid_q;
    err_d      = err_q;
    is_get_d   = is_get_q;
    wr_en_d    = wr_en_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    d_opcode_d = d_opcode_q;
    d_data_d   = d_data_q;
    d_source_d = d_source_q;
    acc_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // a_ready comes up one edge after reset release, then stays up
        // until a request is taken.
        a_ready_d = 1'b1;
        if (a_ready_q && bus.a_valid_i) begin
          a_ready_d  = 1'b0;
          state_d    = ST_ACCESS;
          err_d      = req_err;
          is_get_d   = req_is_get;
          d_source_d = bus.a_source_i;
          // Rejected requests leave the CSR-side fields untouched so they
          // keep showing the last legal access.
          if (!req_err) begin
            addr_d  = bus.a_address_i;
            wdata_d = bus.a_data_i;
            wr_en_d = !req_is_get;
          end
        end
      end
      ST_ACCESS: begin
        acc_en    = !err_q;
        state_d   = ST_RESP;
        d_valid_d = 1'b1;
        if (!err_q && is_get_q) begin
          d_data_d   = bus.rdata_i;
          d_opcode_d = AccessAckData;
        end else begin
          d_data_d   = '0;
          d_opcode_d = AccessAck;
        end
      end
      ST_RESP: begin
        if (bus.d_ready_i) begin
          state_d   = ST_IDLE;
          d_valid_d = 1'b0;
          a_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      a_ready_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      is_get_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      d_opcode_q <= AccessAck;
      d_data_q   <= '0;
      d_source_q <= '0;
    end else begin
      state_q    <= state_d;
      a_ready_q  <= a_ready_d;
      d_valid_q  <= d_valid_d;
      err_q      <= err_d;
      is_get_q   <= is_get_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      d_opcode_q <= d_opcode_d;
      d_data_q   <= d_data_d;
      d_source_q <= d_source_d;
    end
  end

  // acc_en is decoded from registered state only, so an asynchronous reset
  // drops it at once.
  assign bus.acc_en_o   = acc_en;
  assign bus.wr_en_o    = wr_en_q;
  assign bus.addr_o     = addr_q;
  assign bus.wdata_o    = wdata_q;
  assign bus.a_ready_o  = a_ready_q;
  assign bus.d_valid_o  = d_valid_q;
  assign bus.d_opcode_o = d_opcode_q;
  assign bus.d_data_o   = d_data_q;
  assign bus.d_source_o = d_source_q;
  assign bus.d_error_o  = err_q;
  assign dbg_state_o    = state_q;

endmodule
